// File: rtl/ofdm_pkg.sv
// Shared constants and types for the 802.16 OFDM (256-FFT) pilot handling blocks.
// Used by both the receive phase-tracking sequencer and the transmit pilot inserter.
package ofdm_pkg;

  localparam int          N_USED    = 200;
  localparam logic [10:0] PRBS_SEED = 11'h7FF;

  // Used-subcarrier indices of the 8 pilots (subcarriers -88,-63,-38,-13,+13,+38,+63,+88).
  localparam int                        N_PILOTS  = 8;
  localparam logic [N_PILOTS-1:0][7:0]  PILOT_IDX = {8'd187, 8'd162, 8'd137, 8'd112,
                                                     8'd87,  8'd62,  8'd37,  8'd12};
  // Bit k set when pilot k is in group A (value 1-2w); clear bits form group B (1-2~w).
  localparam logic [N_PILOTS-1:0]       PILOT_GRP_A = 8'b1100_0101;

  localparam logic [1:0] ALLOC_DATA = 2'b00;
  localparam logic [1:0] ALLOC_POS  = 2'b01;
  localparam logic [1:0] ALLOC_NEG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } phtrack_state_e;

endpackage

// File: rtl/pilot_prbs.sv
// 11-bit wk pilot-polarity LFSR; w = s[10]^s[8] and stays constant between advances.
// A load request takes priority over an advance in the same cycle.
module pilot_prbs
  import ofdm_pkg::*;
#(
  parameter logic [10:0] SEED = PRBS_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic adv,
  output logic w
);

  logic [10:0] s_q, s_d;

  assign w = s_q[10] ^ s_q[8];

  always_comb begin
    s_d = s_q;
    if (load) begin
      s_d = SEED;
    end else if (adv) begin
      s_d = {s_q[9:0], w};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= SEED;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/phtrack_seq.sv
// Per-symbol sequencer for the pilot phase-tracking estimator: counts used subcarriers,
// flags pilot polarity, issues the estimator clear and checks one estimate per symbol.
module phtrack_seq
  import ofdm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        sym_start,
  input  logic        datin_val,
  input  logic [15:0] datin_Re,
  input  logic [15:0] datin_Im,
  input  logic        est_oval,
  output logic [15:0] dat_Re,
  output logic [15:0] dat_Im,
  output logic        dat_val,
  output logic        est_start,
  output logic [1:0]  alloc_vec,
  output logic [7:0]  sc_idx,
  output logic        sym_done,
  output logic        err
);

  localparam logic [7:0] LAST_IDX = 8'(N_USED - 1);

  phtrack_state_e state_q, state_d;
  logic [7:0]     sc_cnt_q, sc_cnt_d;
  logic           got_est_q, got_est_d;
  logic           multi_est_q, multi_est_d;

  logic           start_acc, restart, accept, first;
  logic [7:0]     idx;
  logic           w, prbs_adv;
  logic [N_PILOTS-1:0] pilot_hit;
  logic           is_pilot, pilot_pos;

  logic [15:0]    dat_re_q, dat_im_q;
  logic           dat_val_q, dat_val_d;
  logic           est_start_q, est_start_d;
  logic [1:0]     alloc_q, alloc_d;
  logic [7:0]     sc_idx_q, sc_idx_d;
  logic           sym_done_q, sym_done_d;
  logic           err_q, err_d;

  assign start_acc = sym_start & datin_val;
  assign restart   = (state_q == ST_RUN) & start_acc & (sc_cnt_q < LAST_IDX);
  assign prbs_adv  = (state_q == ST_DONE);

  pilot_prbs #(.SEED(PRBS_SEED)) u_prbs (
    .clk  (clk),
    .rst  (rst),
    .load (frame_start),
    .adv  (prbs_adv),
    .w    (w)
  );

  // Which sample (if any) is accepted this cycle and what index it carries.
  always_comb begin
    accept = 1'b0;
    first  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        accept = start_acc;
        first  = start_acc;
      end
      ST_RUN: begin
        accept = datin_val;
        first  = restart;
      end
      default: ;
    endcase
    idx = first ? 8'd0 : sc_cnt_q;
  end

  for (genvar gi = 0; gi < N_PILOTS; gi++) begin : g_pilot
    assign pilot_hit[gi] = (idx == PILOT_IDX[gi]);
  end

  assign is_pilot  = |pilot_hit;
  assign pilot_pos = (|(pilot_hit & PILOT_GRP_A)) ^ w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_acc) state_d = ST_RUN;
      ST_RUN:  if (datin_val && !restart && sc_cnt_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE: state_d = start_acc ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sc_cnt_d    = accept ? idx + 8'd1 : sc_cnt_q;
    // The estimate flags restart at index 0; an estimate in that same cycle still counts.
    got_est_d   = first ? est_oval : (got_est_q | est_oval);
    multi_est_d = first ? 1'b0 : (multi_est_q | (got_est_q & est_oval));

    dat_val_d   = accept;
    est_start_d = accept & first;
    sc_idx_d    = accept ? idx : 8'd0;
    alloc_d     = ALLOC_DATA;
    if (accept && is_pilot) begin
      alloc_d = pilot_pos ? ALLOC_POS : ALLOC_NEG;
    end
    sym_done_d  = (state_q == ST_DONE);
    err_d       = restart
                | ((state_q == ST_IDLE) & est_oval)
                | ((state_q == ST_DONE) & (~(got_est_q | est_oval) | multi_est_q
                                           | (got_est_q & est_oval)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_cnt_q    <= 8'd0;
      got_est_q   <= 1'b0;
      multi_est_q <= 1'b0;
      dat_re_q    <= 16'd0;
      dat_im_q    <= 16'd0;
      dat_val_q   <= 1'b0;
      est_start_q <= 1'b0;
      alloc_q     <= ALLOC_DATA;
      sc_idx_q    <= 8'd0;
      sym_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sc_cnt_q    <= sc_cnt_d;
      got_est_q   <= got_est_d;
      multi_est_q <= multi_est_d;
      dat_re_q    <= datin_Re;
      dat_im_q    <= datin_Im;
      dat_val_q   <= dat_val_d;
      est_start_q <= est_start_d;
      alloc_q     <= alloc_d;
      sc_idx_q    <= sc_idx_d;
      sym_done_q  <= sym_done_d;
      err_q       <= err_d;
    end
  end

  assign dat_Re    = dat_re_q;
  assign dat_Im    = dat_im_q;
  assign dat_val   = dat_val_q;
  assign est_start = est_start_q;
  assign alloc_vec = alloc_q;
  assign sc_idx    = sc_idx_q;
  assign sym_done  = sym_done_q;
  assign err       = err_q;

endmodule
